// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage RV32 pipeline.
// Drives a single-outstanding req/ack data bus with byte-lane steering,
// extends load data, and presents a registered result to write-back.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned H/W accesses trap
// without touching the bus instead of ignoring the offending address bits.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_regb,
    input  logic        ex_mem_rd_mem,
    input  logic        ex_mem_wr_mem,
    input  logic [2:0]  ex_mem_funct3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_wb_valid,
    output logic [31:0] mem_wb_result,
    output logic        mem_wb_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Counter value at which a pending access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_q, req_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_result_q, wb_result_d;
    logic        wb_err_q, wb_err_d;

    logic        stall;
    logic        mem_op;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    assign mem_op = ex_mem_rd_mem | ex_mem_wr_mem;

`ifdef MEM_MISALIGN_TRAP_EN
    // Halfword needs bit 0 clear, word needs both low bits clear.
    assign misaligned = ((ex_mem_funct3[1:0] == 2'b01) && ex_mem_alu_result[0]) ||
                        ((ex_mem_funct3[1:0] == 2'b10) && (ex_mem_alu_result[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the instruction in EX/MEM
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = ex_mem_regb;
        case (ex_mem_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << ex_mem_alu_result[1:0];
                wdata_new = {4{ex_mem_regb[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {ex_mem_alu_result[1], 1'b0};
                wdata_new = {2{ex_mem_regb[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection and sign/zero extension of returning load data
    always_comb begin
        case (addr_q[1:0])
            2'b00:   lane_byte = mem_rdata[7:0];
            2'b01:   lane_byte = mem_rdata[15:8];
            2'b10:   lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (funct3_q[1:0])
            2'b00:   load_data = funct3_q[2] ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_data = funct3_q[2] ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: ;
        endcase
    end

    // Next-state, bus latch, stall and write-back result selection
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        req_d       = req_q;
        wb_valid_d  = 1'b0;
        wb_err_d    = 1'b0;
        wb_result_d = wb_result_q;
        stall       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_mem_valid) begin
                    if (!mem_op) begin
                        wb_valid_d  = 1'b1;
                        wb_result_d = ex_mem_alu_result;
                    end else if (misaligned) begin
                        wb_valid_d  = 1'b1;
                        wb_err_d    = 1'b1;
                        wb_result_d = ex_mem_alu_result;
                    end else begin
                        stall    = 1'b1;
                        state_d  = BUSY;
                        cnt_d    = 8'd0;
                        addr_d   = ex_mem_alu_result;
                        funct3_d = ex_mem_funct3;
                        we_d     = ex_mem_wr_mem;
                        be_d     = be_new;
                        wdata_d  = wdata_new;
                        req_d    = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_result_d = we_q ? addr_q : load_data;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_err_d    = 1'b1;
                    wb_result_d = addr_q;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, bus and write-back registers; reset abandons any pending access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= 32'd0;
            funct3_q    <= 3'd0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            req_q       <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_result_q <= 32'd0;
            wb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            req_q       <= req_d;
            wb_valid_q  <= wb_valid_d;
            wb_result_q <= wb_result_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_be        = be_q;
    assign mem_wdata     = wdata_q;
    assign mem_stall     = stall;
    assign mem_wb_valid  = wb_valid_q;
    assign mem_wb_result = wb_result_q;
    assign mem_wb_err    = wb_err_q;

endmodule
